// File: rtl/rr_dec_arb8_pkg.sv
// Shared types and helpers for the rr_dec_arb8 round-robin arbiter.
// Holds the FSM state enum, sizing constants and the one-hot decode rule.
package rr_dec_arb8_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // 3-to-8 decode: out = en ? (1 << idx) : 0
    function automatic logic [NREQ-1:0] dec_1hot(
        input logic             en,
        input logic [IDX_W-1:0] idx
    );
        dec_1hot = en ? (NREQ'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/rr_dec_arb8_pick8.sv
// Combinational rotate-priority picker: first set req bit at or above
// ptr, wrapping from 7 back to 0.
module rr_pick8
    import rr_dec_arb8_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan upward from ptr; 3-bit add gives the 7->0 wrap for free.
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = ptr + IDX_W'(j);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_dec_arb8.sv
// Eight-way round-robin arbiter with a hold timeout and a global enable.
// Winner kept as a 3-bit code; gnt is its registered one-hot decode.
module rr_dec_arb8
    import rr_dec_arb8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             tout
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             tout_q, tout_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             rel;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state logic: grant from IDLE, release on drop or hold limit.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        tout_d     = 1'b0;
        rel        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    state_d    = GRANT;
                    gnt_idx_d  = pick_idx;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = 8'd1;
                end
            end
            GRANT: begin
                rel = !req[gnt_idx_q] ||
                      (hold_cnt_q == HOLD_MAX);
                if (rel) begin
                    state_d    = IDLE;
                    gnt_vld_d  = 1'b0;
                    ptr_d      = gnt_idx_q + 3'd1;
                    hold_cnt_d = 8'd0;
                    // still requesting => the limit cut it
                    tout_d     = req[gnt_idx_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
        gnt_d = dec_1hot(gnt_vld_d, gnt_idx_d);
    end

    // State and output registers; reset clears grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            tout_q     <= 1'b0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            tout_q     <= tout_d;
            gnt_q      <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign tout    = tout_q;

endmodule

// File: tb/tb_rr_dec_arb8.sv
// Scoreboard bench for rr_dec_arb8 at MAX_HOLD 16, 4 and 1.
// All three instances share stimulus; each has its own reference model.
module tb_rr_dec_arb8;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt_o  [NI];
    logic [2:0] idx_o  [NI];
    logic       vld_o  [NI];
    logic       tout_o [NI];

    always #5 clk = ~clk;

    rr_dec_arb8 #(.MAX_HOLD(16)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_o[0]), .gnt_idx(idx_o[0]),
        .gnt_vld(vld_o[0]), .tout(tout_o[0])
    );
    rr_dec_arb8 #(.MAX_HOLD(4)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_o[1]), .gnt_idx(idx_o[1]),
        .gnt_vld(vld_o[1]), .tout(tout_o[1])
    );
    rr_dec_arb8 #(.MAX_HOLD(1)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_o[2]), .gnt_idx(idx_o[2]),
        .gnt_vld(vld_o[2]), .tout(tout_o[2])
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tout;
    } exp_t;

    exp_t       sb [$];
    logic [2:0] ord_a [$];
    logic [2:0] ord_b [$];
    logic       pv [NI];

    logic       m_vld  [NI];
    logic [2:0] m_idx  [NI];
    logic [2:0] m_ptr  [NI];
    int         m_cnt  [NI];
    logic       m_tout [NI];

    int n_vec = 0;
    int n_err = 0;

    function automatic int mh_of(input int k);
        case (k)
            0:       mh_of = 16;
            1:       mh_of = 4;
            default: mh_of = 1;
        endcase
    endfunction

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_rst();
        for (int k = 0; k < NI; k++) begin
            m_vld[k]  = 1'b0;
            m_idx[k]  = 3'd0;
            m_ptr[k]  = 3'd0;
            m_cnt[k]  = 0;
            m_tout[k] = 1'b0;
            pv[k]     = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [2:0] c;
        logic       hit;
        m_tout[k] = 1'b0;
        hit = 1'b0;
        if (!m_vld[k]) begin
            if (en && req != 8'h00) begin
                for (int j = 0; j < 8; j++) begin
                    c = m_ptr[k] + 3'(j);
                    if (!hit && req[c]) begin
                        hit      = 1'b1;
                        m_idx[k] = c;
                    end
                end
                m_vld[k] = 1'b1;
                m_cnt[k] = 1;
            end
        end else if (!req[m_idx[k]] ||
                     m_cnt[k] == mh_of(k)) begin
            m_tout[k] = req[m_idx[k]];
            m_vld[k]  = 1'b0;
            m_ptr[k]  = m_idx[k] + 3'd1;
        end else begin
            m_cnt[k]++;
        end
    endtask

    task automatic cycle(input logic [7:0] r, input logic e);
        exp_t x;
        @(negedge clk);
        req = r;
        en  = e;
        for (int k = 0; k < NI; k++) begin
            model_step(k);
            x.gnt  = m_vld[k] ? (8'h01 << m_idx[k]) : 8'h00;
            x.idx  = m_idx[k];
            x.vld  = m_vld[k];
            x.tout = m_tout[k];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            x = sb.pop_front();
            chk($sformatf("i%0d gnt", k), gnt_o[k], x.gnt);
            chk($sformatf("i%0d idx", k), 8'(idx_o[k]), 8'(x.idx));
            chk($sformatf("i%0d vld", k), 8'(vld_o[k]), 8'(x.vld));
            chk($sformatf("i%0d tout", k), 8'(tout_o[k]), 8'(x.tout));
            if (vld_o[k] && !pv[k]) begin
                if (k == 0) ord_a.push_back(idx_o[k]);
                if (k == 1) ord_b.push_back(idx_o[k]);
            end
            pv[k] = vld_o[k];
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s i%0d gnt", tag, k), gnt_o[k], 8'h00);
            chk($sformatf("%s i%0d idx", tag, k), 8'(idx_o[k]), 8'h00);
            chk($sformatf("%s i%0d vld", tag, k), 8'(vld_o[k]), 8'h00);
            chk($sformatf("%s i%0d tout", tag, k), 8'(tout_o[k]), 8'h00);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b0;
        model_rst();
        @(posedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] qget(input logic [2:0] q [$],
                                        input int i);
        qget = (q.size() > i) ? 8'(q[i]) : 8'hEE;
    endfunction

    initial begin
        logic [7:0] r;
        int         gc;
        logic [2:0] exp4 [4];
        exp4[0] = 3'd0; exp4[1] = 3'd7;
        exp4[2] = 3'd0; exp4[3] = 3'd7;

        // reset, then async reset in the middle of a grant
        do_reset();
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        cycle(8'h04, 1'b1);
        chk("pre-rst gnt", gnt_o[0], 8'h04);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async");
        @(negedge clk);
        req = 8'h00;
        model_rst();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // single request, dropped after three grant cycles
        repeat (3) cycle(8'h04, 1'b1);
        cycle(8'h00, 1'b1);
        chk("t2 drop", gnt_o[0], 8'h00);
        cycle(8'h00, 1'b1);
        cycle(8'h09, 1'b1);
        chk("t2 ptr", 8'(idx_o[0]), 8'h03);
        repeat (2) cycle(8'h00, 1'b1);

        // all requesting: timeout rotation with wrap
        do_reset();
        ord_b.delete();
        repeat (46) cycle(8'hFF, 1'b1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("t3 ord%0d", i), qget(ord_b, i),
                8'(i % 8));
        repeat (2) cycle(8'h00, 1'b1);

        // fairness between 0 and 7 with drop/re-assert
        do_reset();
        ord_a.delete();
        gc = 0;
        repeat (13) begin
            r = 8'h81;
            if (m_vld[0]) begin
                gc++;
                if (gc == 2) begin
                    r[m_idx[0]] = 1'b0;
                    gc = 0;
                end
            end
            cycle(r, 1'b1);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4 ord%0d", i), qget(ord_a, i),
                8'(exp4[i]));
        repeat (2) cycle(8'h00, 1'b1);

        // enable gating
        do_reset();
        ord_a.delete();
        ord_b.delete();
        cycle(8'h20, 1'b1);
        repeat (20) cycle(8'hFF, 1'b0);
        chk("t5 no regrant a", 8'(ord_a.size()), 8'd1);
        chk("t5 no regrant b", 8'(ord_b.size()), 8'd1);
        cycle(8'hFF, 1'b1);
        chk("t5 next a", qget(ord_a, 1), 8'd6);
        chk("t5 next b", qget(ord_b, 1), 8'd6);
        repeat (2) cycle(8'h00, 1'b1);
        repeat (2) cycle(8'h00, 1'b1);

        // drop coinciding with the hold limit (MAX_HOLD=4)
        do_reset();
        repeat (4) cycle(8'h01, 1'b1);
        cycle(8'h00, 1'b1);
        chk("t6 tout", 8'(tout_o[1]), 8'h00);
        chk("t6 vld", 8'(vld_o[1]), 8'h00);
        cycle(8'h03, 1'b1);
        chk("t6 ptr", 8'(idx_o[1]), 8'h01);
        repeat (2) cycle(8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
